// File: rtl/uart_tx_ser.sv
// uart_tx_ser: 8N1 UART serializer, BIT_CELL sys_clk cycles per bit, LSB first.
// Ports: sys_clk/sys_rst (async, active-high), xmitH + xmit_dataH load a byte while
// xmit_readyH=1; uart_xmitH is the registered serial line (idle 1); xmit_busyH is
// high while a frame is on the line; xmit_doneH pulses the cycle after the last stop cell.
// Optional UART_TX_HOLD_EN: one-entry holding register so frames chain with no idle gap.
module uart_tx_ser #(
  parameter int BIT_CELL = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       xmitH,
  input  logic [7:0] xmit_dataH,
  output logic       uart_xmitH,
  output logic       xmit_readyH,
  output logic       xmit_busyH,
  output logic       xmit_doneH
);
  localparam int CW = $clog2(BIT_CELL);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;
  stateT         state;
  logic [CW-1:0] cellCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          cellEnd;
  logic          loadNow;
  assign cellEnd    = cellCnt == CW'(BIT_CELL - 1);
  assign xmit_busyH = state != IDLE;
  assign loadNow    = xmitH && xmit_readyH;
`ifdef UART_TX_HOLD_EN
  logic [7:0] holdReg;
  logic       holdFull;
  assign xmit_readyH = !holdFull;
`else
  assign xmit_readyH = state == IDLE;
`endif
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state      <= IDLE;
      cellCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      uart_xmitH <= 1'b1;
      xmit_doneH <= 1'b0;
`ifdef UART_TX_HOLD_EN
      holdReg    <= '0;
      holdFull   <= 1'b0;
`endif
    end else begin
      xmit_doneH <= 1'b0;
      cellCnt    <= (state == IDLE || cellEnd) ? '0 : cellCnt + 1'b1;
      case (state)
        IDLE:
          if (loadNow) begin
            state      <= START;
            shiftReg   <= xmit_dataH;
            uart_xmitH <= 1'b0;
          end
        START:
          if (cellEnd) begin
            state      <= DATA;
            bitCnt     <= '0;
            uart_xmitH <= shiftReg[0];
          end
        DATA:
          if (cellEnd) begin
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) begin
              state      <= STOP;
              uart_xmitH <= 1'b1;
            end else begin
              shiftReg   <= shiftReg >> 1;
              uart_xmitH <= shiftReg[1];
            end
          end
        STOP:
          if (cellEnd) begin
            xmit_doneH <= 1'b1;
`ifdef UART_TX_HOLD_EN
            // a held byte wins; otherwise a load arriving on this very edge chains directly
            if (holdFull) begin
              state      <= START;
              shiftReg   <= holdReg;
              holdFull   <= 1'b0;
              uart_xmitH <= 1'b0;
            end else if (xmitH) begin
              state      <= START;
              shiftReg   <= xmit_dataH;
              uart_xmitH <= 1'b0;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        default: state <= IDLE;
      endcase
`ifdef UART_TX_HOLD_EN
      if (loadNow && state != IDLE && !(state == STOP && cellEnd)) begin
        holdReg  <= xmit_dataH;
        holdFull <= 1'b1;
      end
`endif
    end
endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: scoreboard plus cycle-exact frame checks for uart_tx_ser.
module tb_uart_tx_ser;
  localparam int BC = 16;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       xmitH = 1'b0;
  logic       xmit2 = 1'b0;
  logic [7:0] dataH = '0;
  logic [7:0] data2 = '0;
  logic       line, ready, busy, done;
  logic       line2, ready2, busy2, done2;
  int         vecs = 0;
  int         errs = 0;
  logic [7:0] q[$];

  always #5 sys_clk = ~sys_clk;

  uart_tx_ser #(.BIT_CELL(BC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .xmitH(xmitH), .xmit_dataH(dataH),
    .uart_xmitH(line), .xmit_readyH(ready), .xmit_busyH(busy), .xmit_doneH(done)
  );

  uart_tx_ser #(.BIT_CELL(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .xmitH(xmit2), .xmit_dataH(data2),
    .uart_xmitH(line2), .xmit_readyH(ready2), .xmit_busyH(busy2), .xmit_doneH(done2)
  );

  function automatic logic expLine(input logic [7:0] b, input int c, input int bc);
    int k;
    k = (c - 1) / bc;
    return k == 0 ? 1'b0 : k <= 8 ? b[k-1] : 1'b1;
  endfunction

  task automatic loadByte(input logic [7:0] b);
    @(negedge sys_clk);
    xmitH = 1'b1;
    dataH = b;
    @(posedge sys_clk);
    #1 xmitH = 1'b0;
    dataH = ~b;
  endtask

  initial begin : monitor
    logic [7:0] got;
    logic [7:0] e;
    bit         ok;
    int         k;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && line === 1'b0) begin
        got = '0;
        ok  = 1'b1;
        for (int c = 2; c <= 10 * BC; c++) begin
          @(negedge sys_clk);
          if (sys_rst) begin
            ok = 1'b0;
            break;
          end
          if ((c - 1) % BC == BC / 2) begin
            k = (c - 1) / BC;
            if (k == 0) begin
              vecs++;
              if (line !== 1'b0) begin errs++; $display("FAIL mon_start got=%b exp=0", line); end
            end else if (k <= 8) begin
              got[k-1] = line;
            end else begin
              vecs++;
              if (line !== 1'b1) begin errs++; $display("FAIL mon_stop got=%b exp=1", line); end
            end
          end
        end
        if (ok) begin
          vecs++;
          if (q.size() == 0) begin
            errs++;
            $display("FAIL mon_unexpected_frame got=%02h exp=none", got);
          end else begin
            e = q.pop_front();
            if (got !== e) begin errs++; $display("FAIL mon_byte got=%02h exp=%02h", got, e); end
          end
        end
      end
    end
  end

  task automatic test_reset;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    vecs += 5;
    if (line !== 1'b1) begin errs++; $display("FAIL rst_line got=%b exp=1", line); end
    if (done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b exp=1", ready); end
    if (line2 !== 1'b1) begin errs++; $display("FAIL rst_line2 got=%b exp=1", line2); end
    #2 sys_rst = 1'b0;
    @(negedge sys_clk);
    vecs += 3;
    if (ready !== 1'b1) begin errs++; $display("FAIL post_rst_ready got=%b exp=1", ready); end
    if (busy !== 1'b0) begin errs++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    if (line !== 1'b1) begin errs++; $display("FAIL post_rst_line got=%b exp=1", line); end
  endtask

  task automatic test_single;
    q.push_back(8'hA5);
    loadByte(8'hA5);
    for (int c = 1; c <= 161; c++) begin
      @(negedge sys_clk);
      vecs += 3;
      if (line !== (c <= 160 ? expLine(8'hA5, c, BC) : 1'b1)) begin
        errs++; $display("FAIL single_line c=%0d got=%b", c, line);
      end
      if (done !== (c == 161)) begin errs++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done, c == 161); end
      if (busy !== (c <= 160)) begin errs++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, c <= 160); end
    end
  endtask

  task automatic test_patterns;
    logic [7:0] pats[3] = '{8'h00, 8'hFF, 8'h3C};
    int n;
    foreach (pats[i]) begin
      q.push_back(pats[i]);
      loadByte(pats[i]);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
        @(negedge sys_clk);
        n++;
      end
      vecs++;
      if (n != 161) begin errs++; $display("FAIL pat_done_cycle byte=%02h got=%0d exp=161", pats[i], n); end
    end
  endtask

  task automatic test_busy_load;
    logic expL, expD, expB;
    q.push_back(8'h55);
`ifdef UART_TX_HOLD_EN
    q.push_back(8'h99);
`endif
    loadByte(8'h55);
    for (int c = 1; c <= 330; c++) begin
      @(negedge sys_clk);
`ifdef UART_TX_HOLD_EN
      expL = c <= 160 ? expLine(8'h55, c, BC) : c <= 320 ? expLine(8'h99, c - 160, BC) : 1'b1;
      expD = c == 161 || c == 321;
      expB = c <= 320;
`else
      expL = c <= 160 ? expLine(8'h55, c, BC) : 1'b1;
      expD = c == 161;
      expB = c <= 160;
`endif
      vecs += 3;
      if (line !== expL) begin errs++; $display("FAIL busy_line c=%0d got=%b exp=%b", c, line, expL); end
      if (done !== expD) begin errs++; $display("FAIL busy_done c=%0d got=%b exp=%b", c, done, expD); end
      if (busy !== expB) begin errs++; $display("FAIL busy_busy c=%0d got=%b exp=%b", c, busy, expB); end
      if (c == 39 || c == 41) begin
        vecs++;
`ifdef UART_TX_HOLD_EN
        if (ready !== (c == 39)) begin errs++; $display("FAIL busy_ready c=%0d got=%b exp=%b", c, ready, c == 39); end
`else
        if (ready !== 1'b0) begin errs++; $display("FAIL busy_ready c=%0d got=%b exp=0", c, ready); end
`endif
      end
      if (c == 40) begin
        xmitH = 1'b1;
        dataH = 8'h99;
      end else if (c == 41) begin
        xmitH = 1'b0;
        dataH = 8'h00;
      end
    end
  endtask

  task automatic test_reset_mid;
    q.push_back(8'hC3);
    loadByte(8'hC3);
    repeat (70) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    vecs += 3;
    if (line !== 1'b1) begin errs++; $display("FAIL mid_rst_line got=%b exp=1", line); end
    if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    if (ready !== 1'b1) begin errs++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
    q.delete();
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge sys_clk);
      vecs += 2;
      if (done !== 1'b0) begin errs++; $display("FAIL mid_rst_done c=%0d got=%b exp=0", c, done); end
      if (line !== 1'b1) begin errs++; $display("FAIL mid_rst_idle c=%0d got=%b exp=1", c, line); end
    end
  endtask

  task automatic test_min_cell;
    @(negedge sys_clk);
    vecs++;
    if (ready2 !== 1'b1) begin errs++; $display("FAIL min_ready got=%b exp=1", ready2); end
    xmit2 = 1'b1;
    data2 = 8'h01;
    @(posedge sys_clk);
    #1 xmit2 = 1'b0;
    data2 = 8'hFE;
    for (int c = 1; c <= 22; c++) begin
      @(negedge sys_clk);
      vecs += 3;
      if (line2 !== (c <= 20 ? expLine(8'h01, c, 2) : 1'b1)) begin
        errs++; $display("FAIL min_line c=%0d got=%b", c, line2);
      end
      if (done2 !== (c == 21)) begin errs++; $display("FAIL min_done c=%0d got=%b exp=%b", c, done2, c == 21); end
      if (busy2 !== (c <= 20)) begin errs++; $display("FAIL min_busy c=%0d got=%b exp=%b", c, busy2, c <= 20); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    test_reset();
    test_single();
    test_patterns();
    test_busy_load();
    test_reset_mid();
    test_min_cell();
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    vecs++;
    if (q.size() != 0) begin errs++; $display("FAIL scoreboard_drain got=%0d exp=0", q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
